// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] inst;
      logic            valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{pc4: '0, inst: NOP_INST, valid: 1'b0};

   // Sequential PC increment; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return XLEN'(pc + PC_STEP);
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, hold blocks load, otherwise keeps its contents.
module ifid_reg
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            flush,
   input  logic            hold,
   input  logic [XLEN-1:0] load_pc4,
   input  logic [XLEN-1:0] load_inst,
   output logic [XLEN-1:0] ifid_pc4,
   output logic [XLEN-1:0] ifid_inst,
   output logic            ifid_valid
);

   ifid_t ifid_d;
   ifid_t ifid_q;

   always_comb begin
      ifid_d = ifid_q;
      if (flush) begin
         ifid_d = IFID_BUBBLE;
      end else if (load && !hold) begin
         ifid_d = '{pc4: load_pc4, inst: load_inst, valid: 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_q <= IFID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid_pc4   = ifid_q.pc4;
   assign ifid_inst  = ifid_q.inst;
   assign ifid_valid = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, sequences a variable-latency imem request and fills IF/ID.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        ifid_write,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_inst,
   output logic        ifid_valid
);

   fetch_state_t    state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] hold_inst_d, hold_inst_q;
   logic [XLEN-1:0] pending_d, pending_q;

   logic            advance;
   logic            ifid_load;
   logic            ifid_flush;
   logic [XLEN-1:0] ifid_load_inst;
   logic [XLEN-1:0] pc_plus4;

   assign advance  = pc_write & ifid_write;
   assign pc_plus4 = pc_inc(pc_q);

   // The address only moves on a state/pc update, so it is stable across wait states.
   assign imem_req  = (state_q != HOLD) && !rst;
   assign imem_addr = pc_q;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      hold_inst_d    = hold_inst_q;
      pending_d      = pending_q;
      ifid_load      = 1'b0;
      ifid_flush     = 1'b0;
      ifid_load_inst = imem_rdata;

      unique case (state_q)
         REQ: begin
            if (imem_ready) begin
               if (redirect) begin
                  pc_d       = redirect_pc;
                  ifid_flush = 1'b1;
               end else if (advance) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end else begin
                  hold_inst_d = imem_rdata;
                  state_d     = HOLD;
               end
            end else begin
               if (redirect) begin
                  pending_d  = redirect_pc;
                  ifid_flush = 1'b1;
                  state_d    = DISCARD;
               end else if (advance) begin
                  ifid_flush = 1'b1;
               end
            end
         end

         HOLD: begin
            if (redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
               state_d    = REQ;
            end else if (advance) begin
               ifid_load      = 1'b1;
               ifid_load_inst = hold_inst_q;
               pc_d           = pc_plus4;
               state_d        = REQ;
            end
         end

         DISCARD: begin
            // The in-flight response belongs to the abandoned path; the newest target wins.
            if (redirect) begin
               pending_d = redirect_pc;
            end
            if (imem_ready) begin
               pc_d    = redirect ? redirect_pc : pending_q;
               state_d = REQ;
            end
            ifid_flush = advance | redirect;
         end

         default: begin
            state_d = REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         hold_inst_q <= '0;
         pending_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_inst_q <= hold_inst_d;
         pending_q   <= pending_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (ifid_load),
      .flush      (ifid_flush),
      .hold       (!ifid_write),
      .load_pc4   (pc_plus4),
      .load_inst  (ifid_load_inst),
      .ifid_pc4   (ifid_pc4),
      .ifid_inst  (ifid_inst),
      .ifid_valid (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-driven imem with hand-computed IF/ID and address values.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        pc_write;
   logic        ifid_write;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_inst;
   logic        ifid_valid;

   int checks   = 0;
   int failures = 0;

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .ifid_pc4    (ifid_pc4),
      .ifid_inst   (ifid_inst),
      .ifid_valid  (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc4,
                             input logic [31:0] inst, input logic valid);
      check({tag, ".valid"}, 32'(ifid_valid), 32'(valid));
      check({tag, ".pc4"}, ifid_pc4, pc4);
      check({tag, ".inst"}, ifid_inst, inst);
   endtask

   task automatic set_adv(input logic a);
      pc_write   = a;
      ifid_write = a;
   endtask

   task automatic jump(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      imem_ready  = 1'b1;
      step();
      redirect    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; set_adv(1'b1); redirect = 1'b0; redirect_pc = '0;
      imem_ready = 1'b1; imem_rdata = '0;

      // Reset
      #1;
      check("rst_req_low", 32'(imem_req), 32'd0);
      step();
      check("rst_req_low2", 32'(imem_req), 32'd0);
      check("rst_pc", imem_addr, 32'h0040_0000);
      check_ifid("rst_ifid", 32'h0, 32'h0, 1'b0);

      // Zero-wait sequential fetch
      rst = 1'b0; #1;
      check("seq0_req", 32'(imem_req), 32'd1);
      check("seq0_addr", imem_addr, 32'h0040_0000);
      imem_rdata = 32'h1111_1111; step();
      check_ifid("seq1", 32'h0040_0004, 32'h1111_1111, 1'b1);
      check("seq1_addr", imem_addr, 32'h0040_0004);
      imem_rdata = 32'h2222_2222; step();
      check_ifid("seq2", 32'h0040_0008, 32'h2222_2222, 1'b1);
      check("seq2_addr", imem_addr, 32'h0040_0008);

      // Load-use stall with response captured into HOLD
      jump(32'h0000_000C);
      check_ifid("jmpC", 32'h0, 32'h0, 1'b0);
      check("jmpC_addr", imem_addr, 32'h0000_000C);
      imem_rdata = 32'hAAAA_0000; step();
      check_ifid("pre_stall", 32'h10, 32'hAAAA_0000, 1'b1);
      check("pre_stall_addr", imem_addr, 32'h10);
      set_adv(1'b0); imem_rdata = 32'h8C01_0004; step();
      check("hold_req", 32'(imem_req), 32'd0);
      check_ifid("hold_ifid", 32'h10, 32'hAAAA_0000, 1'b1);
      imem_rdata = 32'hDEAD_BEEF; step();
      check_ifid("hold2_ifid", 32'h10, 32'hAAAA_0000, 1'b1);
      set_adv(1'b1); step();
      check_ifid("release", 32'h14, 32'h8C01_0004, 1'b1);
      check("release_addr", imem_addr, 32'h14);
      check("release_req", 32'(imem_req), 32'd1);

      // Redirect with ready
      jump(32'h0000_0040);
      check("at40_addr", imem_addr, 32'h40);
      imem_rdata = 32'h4040_4040; jump(32'h0000_0200);
      check_ifid("redir_bubble", 32'h0, 32'h0, 1'b0);
      check("redir_addr", imem_addr, 32'h200);
      imem_rdata = 32'h2000_2000; step();
      check_ifid("redir_target", 32'h204, 32'h2000_2000, 1'b1);

      // Redirect during a 3-wait-state fetch at 0x80
      jump(32'h0000_0080);
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; step();
      redirect = 1'b0;
      check("disc_addr1", imem_addr, 32'h80);
      check("disc_req1", 32'(imem_req), 32'd1);
      check_ifid("disc1", 32'h0, 32'h0, 1'b0);
      step();
      check("disc_addr2", imem_addr, 32'h80);
      step();
      check("disc_addr3", imem_addr, 32'h80);
      imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD; step();
      check("disc_drain_addr", imem_addr, 32'h300);
      check_ifid("disc_drain", 32'h0, 32'h0, 1'b0);
      imem_rdata = 32'h3000_3000; step();
      check_ifid("disc_target", 32'h304, 32'h3000_3000, 1'b1);

      // Second redirect in DISCARD wins
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; step();
      redirect_pc = 32'h340; step();
      redirect = 1'b0;
      check("disc2_addr", imem_addr, 32'h304);
      imem_ready = 1'b1; step();
      check("disc2_target", imem_addr, 32'h340);

      // Wait state without redirect inserts a bubble
      imem_ready = 1'b0; step();
      check_ifid("wait_bubble", 32'h0, 32'h0, 1'b0);
      check("wait_addr", imem_addr, 32'h340);
      imem_ready = 1'b1; imem_rdata = 32'h3400_0001; step();
      check_ifid("wait_done", 32'h344, 32'h3400_0001, 1'b1);

      // Redirect overrides stall
      set_adv(1'b0); jump(32'h0000_0500);
      check("flush_stall_valid", 32'(ifid_valid), 32'd0);
      check("flush_stall_addr", imem_addr, 32'h500);
      set_adv(1'b1);

      // PC wrap
      jump(32'hFFFF_FFFC);
      imem_rdata = 32'h1234_5678; step();
      check_ifid("wrap", 32'h0, 32'h1234_5678, 1'b1);
      check("wrap_addr", imem_addr, 32'h0);

      // Reset while in DISCARD
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h600; step();
      redirect = 1'b0; rst = 1'b1; #1;
      check("rstd_req_low", 32'(imem_req), 32'd0);
      step();
      check("rstd_req_low2", 32'(imem_req), 32'd0);
      check("rstd_pc", imem_addr, 32'h0040_0000);
      check("rstd_valid", 32'(ifid_valid), 32'd0);
      rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h5555_5555; #1;
      check("rstd_req", 32'(imem_req), 32'd1);
      step();
      check_ifid("rstd_fetch", 32'h0040_0004, 32'h5555_5555, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
